pulse_to_level: RTL and testbench
=================================

// Module: pulse_to_level
// PURPOSE
//  Turns single-cycle pulses (typically from the edge-detector FSMs) back into levels for LEDs,
//  enables and slow consumers. Two modes: stretch (level held for a programmable cycle count)
//  and toggle (each pulse flips the level). Sits between pulse-domain control logic and level-domain outputs.
// PARAMETERS
//  CNT_W       8  width of hold_len and the internal down-counter
//  RETRIGGER   1  1: a pulse while high reloads the hold count; 0: the pulse is ignored and flagged dropped
//  GAP_CYCLES  1  forced-low cycles after a stretch ends, in stretch mode only; 0 = no gap
// PORTS
//  clk       in   1      clock, rising edge
//  reset     in   1      synchronous, active-high
//  p_in      in   1      input pulse; every sampled-high cycle counts as one pulse
//  mode      in   1      0 = stretch, 1 = toggle; sampled only in S_IDLE
//  hold_len  in   CNT_W  stretch length in cycles; 0 is treated as 1; sampled on each trigger/reload
//  level     out  1      registered output level
//  busy      out  1      state != S_IDLE
//  dropped   out  1      1-cycle flag: a pulse was discarded
// BEHAVIOUR
//  - Reset: state=S_IDLE, level=0, busy=0, dropped=0, cnt=0, mode_q=0. Reset mid-operation drops level at the next edge.
//  - States: S_IDLE, S_HIGH, S_GAP. level = (state==S_HIGH); busy = (state!=S_IDLE); all outputs registered.
//  - Latency: a pulse sampled at edge t gives level=1 from cycle t+1.
//  - S_IDLE: mode_q<=mode.
//      stretch: on p_in -> S_HIGH, cnt<=max(hold_len,1)-1.
//      toggle:  on p_in -> S_HIGH.
//  - S_HIGH, stretch:
//      p_in && RETRIGGER   -> cnt<=max(hold_len,1)-1, stay in S_HIGH. Reload wins over expiry in the same cycle.
//      p_in && !RETRIGGER  -> dropped<=1, pulse has no other effect.
//      cnt==0 and no reload -> S_GAP with cnt<=GAP_CYCLES-1 when GAP_CYCLES>0; otherwise S_IDLE.
//      else cnt<=cnt-1.
//      Result: level is high for exactly max(hold_len,1) cycles after the last accepted pulse.
//  - S_HIGH, toggle: on p_in -> S_IDLE (level falls next cycle). No timeout; cnt is unused.
//  - S_GAP: level=0. Any p_in -> dropped<=1. cnt==0 -> S_IDLE, else cnt<=cnt-1.
//      Lasts exactly GAP_CYCLES cycles. A pulse in the last gap cycle is dropped.
//  - mode changes outside S_IDLE are ignored until the FSM returns to S_IDLE.
//  - p_in held high continuously:
//      stretch, RETRIGGER=1: level stays high until hold_len cycles after p_in falls.
//      toggle: level alternates every cycle.
//  - dropped is high for exactly one cycle per discarded pulse and is 0 in every other cycle.
//  - Counter arithmetic is unsigned CNT_W. The maximum hold is 2**CNT_W-1 cycles; no wrap is possible.
// STRUCTURE
//  - Package pulse_pkg: typedef enum logic [1:0] {S_IDLE,S_HIGH,S_GAP} p2l_state_t;
//    localparams MODE_STRETCH=1'b0, MODE_TOGGLE=1'b1.
//  - Single module:
//      one always_ff for state/cnt/mode_q/level/dropped,
//      one always_comb for next-state/next-count.
//  - No sub-module; the down-counter is inline.
// TESTING
//  1 stretch, hold_len=4, GAP=1: p_in pulse at edge 10 -> level=1 in cycles 11..14,
//    0 in gap cycle 15, busy falls at 16.
//  2 RETRIGGER=1, hold_len=4: pulses at edges 10 and 12 -> level high cycles 11..16, dropped never set.
//    Repeat with RETRIGGER=0 -> level high 11..14, dropped=1 in cycle 13 only.
//  3 hold_len=0: pulse at edge 5 -> level high in cycle 6 only.
//    hold_len=255 -> level high for 255 cycles.
//  4 toggle mode: pulses at edges 3, 7, 8 -> level=1 in cycles 4..7, 0 in cycle 8, 1 from cycle 9.
//    Change mode to stretch while high -> no effect until level=0.
//  5 GAP_CYCLES=3: pulse arriving in each of the 3 gap cycles -> dropped=1 for each, level stays 0.
//    Pulse in the first S_IDLE cycle -> accepted.
//  6 reset asserted in cycle 12 of scenario 1 -> level=0, busy=0 at the next edge.
//    A pulse right after reset release -> normal 1-cycle latency.

Source files
------------

// File: rtl/pulse_to_level_pkg.sv
// Shared types and mode encodings for the pulse-to-level converter.
// The FSM state is a three-valued enum so the state register reads cleanly in waves.
package pulse_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } p2l_state_t;

    localparam logic MODE_STRETCH = 1'b0;
    localparam logic MODE_TOGGLE  = 1'b1;

endpackage

// File: rtl/pulse_to_level.sv
// Converts single-cycle pulses into levels: stretch (held for hold_len cycles,
// optional forced-low gap afterwards) or toggle (each pulse flips the level).
module pulse_to_level
    import pulse_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter bit RETRIGGER  = 1'b1,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p_in,
    input  logic             mode,
    input  logic [CNT_W-1:0] hold_len,
    output logic             level,
    output logic             busy,
    output logic             dropped
);

    // Handshake: none. p_in is a plain sampled input; every cycle it is high
    // at a rising edge counts as one pulse, with no back-pressure.

    localparam logic [CNT_W-1:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    p2l_state_t       state;
    p2l_state_t       state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             mode_q;
    logic             mode_n;
    logic             dropped_n;
    logic [CNT_W-1:0] hold_load;

    // A hold length of zero behaves as one cycle.
    assign hold_load = (hold_len == '0) ? '0 : (hold_len - CNT_W'(1));

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        mode_n    = mode_q;
        dropped_n = 1'b0;

        unique case (state)
            S_IDLE: begin
                mode_n = mode;
                if (p_in) begin
                    state_n = S_HIGH;
                    if (mode == MODE_STRETCH) begin
                        cnt_n = hold_load;
                    end
                end
            end

            S_HIGH: begin
                if (mode_q == MODE_TOGGLE) begin
                    if (p_in) begin
                        state_n = S_IDLE;
                    end
                end else if (p_in && RETRIGGER) begin
                    // Reload takes priority over expiry in the same cycle.
                    cnt_n = hold_load;
                end else begin
                    if (p_in) begin
                        dropped_n = 1'b1;
                    end
                    if (cnt == '0) begin
                        if (GAP_CYCLES > 0) begin
                            state_n = S_GAP;
                            cnt_n   = GAP_LOAD;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
            end

            S_GAP: begin
                if (p_in) begin
                    dropped_n = 1'b1;
                end
                if (cnt == '0) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state so they line up with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            mode_q  <= MODE_STRETCH;
            level   <= 1'b0;
            busy    <= 1'b0;
            dropped <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            mode_q  <= mode_n;
            level   <= (state_n == S_HIGH);
            busy    <= (state_n != S_IDLE);
            dropped <= dropped_n;
        end
    end

endmodule

// File: tb/tb_pulse_to_level.sv
// Directed bench for pulse_to_level: three instances with different
// RETRIGGER / GAP_CYCLES share stimulus; each scenario checks one of them.
module tb_pulse_to_level;

    localparam int DUT_A = 0;  // RETRIGGER=1, GAP=1
    localparam int DUT_B = 1;  // RETRIGGER=0, GAP=1
    localparam int DUT_C = 2;  // RETRIGGER=1, GAP=3

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       p_in = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] hold_len = 8'd4;
    logic [2:0] lv;
    logic [2:0] bz;
    logic [2:0] dr;

    int    vectors = 0;
    int    miscompares = 0;
    int    idx = 0;
    string scen = "reset";

    always #5 clk = ~clk;

    pulse_to_level #(.CNT_W(8), .RETRIGGER(1'b1), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .p_in(p_in), .mode(mode), .hold_len(hold_len),
        .level(lv[0]), .busy(bz[0]), .dropped(dr[0])
    );

    pulse_to_level #(.CNT_W(8), .RETRIGGER(1'b0), .GAP_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .p_in(p_in), .mode(mode), .hold_len(hold_len),
        .level(lv[1]), .busy(bz[1]), .dropped(dr[1])
    );

    pulse_to_level #(.CNT_W(8), .RETRIGGER(1'b1), .GAP_CYCLES(3)) dut_c (
        .clk(clk), .reset(reset), .p_in(p_in), .mode(mode), .hold_len(hold_len),
        .level(lv[2]), .busy(bz[2]), .dropped(dr[2])
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive p_in for one edge, then check the selected instance just after it.
    task automatic step(input logic p, input int sel,
                        input logic el, input logic eb, input logic ed);
        p_in = p;
        @(posedge clk);
        #1;
        idx++;
        chk($sformatf("%s.%0d.level", scen, idx), lv[sel], el);
        chk($sformatf("%s.%0d.busy", scen, idx), bz[sel], eb);
        chk($sformatf("%s.%0d.dropped", scen, idx), dr[sel], ed);
    endtask

    task automatic idle(input int n);
        p_in = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic begin_scen(input string name);
        scen = name;
        idx  = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("reset.level%0d", s), lv[s], 1'b0);
            chk($sformatf("reset.busy%0d", s), bz[s], 1'b0);
            chk($sformatf("reset.dropped%0d", s), dr[s], 1'b0);
        end
        reset = 1'b0;
        idle(2);

        // Stretch, hold 4, one gap cycle.
        begin_scen("stretch4");
        mode = 1'b0; hold_len = 8'd4;
        step(1, DUT_A, 1, 1, 0);
        step(0, DUT_A, 1, 1, 0);
        step(0, DUT_A, 1, 1, 0);
        step(0, DUT_A, 1, 1, 0);
        step(0, DUT_A, 0, 1, 0);
        step(0, DUT_A, 0, 0, 0);
        idle(8);

        // Retrigger two cycles later extends the level.
        begin_scen("retrig");
        step(1, DUT_A, 1, 1, 0);
        step(0, DUT_A, 1, 1, 0);
        step(1, DUT_A, 1, 1, 0);
        step(0, DUT_A, 1, 1, 0);
        step(0, DUT_A, 1, 1, 0);
        step(0, DUT_A, 1, 1, 0);
        step(0, DUT_A, 0, 1, 0);
        step(0, DUT_A, 0, 0, 0);
        idle(8);

        // Same stimulus without retrigger: second pulse dropped.
        begin_scen("noretrig");
        step(1, DUT_B, 1, 1, 0);
        step(0, DUT_B, 1, 1, 0);
        step(1, DUT_B, 1, 1, 1);
        step(0, DUT_B, 1, 1, 0);
        step(0, DUT_B, 0, 1, 0);
        step(0, DUT_B, 0, 0, 0);
        idle(8);

        // hold_len 0 behaves as 1.
        begin_scen("hold0");
        hold_len = 8'd0;
        step(1, DUT_A, 1, 1, 0);
        step(0, DUT_A, 0, 1, 0);
        step(0, DUT_A, 0, 0, 0);
        idle(8);

        // Maximum hold: 255 cycles high.
        begin_scen("hold255");
        hold_len = 8'd255;
        step(1, DUT_A, 1, 1, 0);
        for (int i = 0; i < 254; i++) begin
            step(0, DUT_A, 1, 1, 0);
        end
        step(0, DUT_A, 0, 1, 0);
        step(0, DUT_A, 0, 0, 0);
        idle(8);

        // Toggle: pulses at rel 0, 4, 5.
        begin_scen("toggle");
        mode = 1'b1; hold_len = 8'd1;
        step(1, DUT_A, 1, 1, 0);
        step(0, DUT_A, 1, 1, 0);
        step(0, DUT_A, 1, 1, 0);
        step(0, DUT_A, 1, 1, 0);
        step(1, DUT_A, 0, 0, 0);
        step(1, DUT_A, 1, 1, 0);
        // Mode change while high is ignored: no timeout, next pulse still toggles.
        mode = 1'b0;
        step(0, DUT_A, 1, 1, 0);
        step(0, DUT_A, 1, 1, 0);
        step(0, DUT_A, 1, 1, 0);
        step(1, DUT_A, 0, 0, 0);
        step(0, DUT_A, 0, 0, 0);
        // Now back in idle the stretch mode takes effect.
        step(1, DUT_A, 1, 1, 0);
        step(0, DUT_A, 0, 1, 0);
        step(0, DUT_A, 0, 0, 0);
        idle(8);

        // Toggle with p_in held high alternates every cycle.
        begin_scen("toggle_held");
        mode = 1'b1;
        step(1, DUT_A, 1, 1, 0);
        step(1, DUT_A, 0, 0, 0);
        step(1, DUT_A, 1, 1, 0);
        step(1, DUT_A, 0, 0, 0);
        mode = 1'b0;
        idle(8);

        // Gap of 3: pulses in every gap cycle dropped, first idle cycle accepted.
        begin_scen("gap3");
        hold_len = 8'd1;
        step(1, DUT_C, 1, 1, 0);
        step(0, DUT_C, 0, 1, 0);
        step(1, DUT_C, 0, 1, 1);
        step(1, DUT_C, 0, 1, 1);
        step(1, DUT_C, 0, 0, 1);
        step(1, DUT_C, 1, 1, 0);
        step(0, DUT_C, 0, 1, 0);
        step(0, DUT_C, 0, 1, 0);
        step(0, DUT_C, 0, 1, 0);
        step(0, DUT_C, 0, 0, 0);
        idle(8);

        // Reset mid-stretch, then a fresh pulse with normal latency.
        begin_scen("midreset");
        hold_len = 8'd4;
        step(1, DUT_A, 1, 1, 0);
        step(0, DUT_A, 1, 1, 0);
        reset = 1'b1;
        step(0, DUT_A, 0, 0, 0);
        reset = 1'b0;
        step(1, DUT_A, 1, 1, 0);
        step(0, DUT_A, 1, 1, 0);
        step(0, DUT_A, 1, 1, 0);
        step(0, DUT_A, 1, 1, 0);
        step(0, DUT_A, 0, 1, 0);
        step(0, DUT_A, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
